// File: rtl/vx_commit_reassembler.sv
// rtl/vx_commit_reassembler.sv - rebuilds full-warp writeback packets from NUM_LANES-wide commit beats
module vx_commit_reassembler #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int PC_BITS     = 32,
  parameter int UUID_WIDTH  = 1,
  parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [UUID_WIDTH-1:0]         in_uuid,
  input  logic [NW_BITS-1:0]            in_wid,
  input  logic [NUM_LANES-1:0]          in_tmask,
  input  logic [PC_BITS-1:0]            in_pc,
  input  logic [NR_BITS-1:0]            in_rd,
  input  logic                          in_wb,
  input  logic [NUM_LANES*XLEN-1:0]     in_data,
  input  logic [PID_WIDTH-1:0]          in_pid,
  input  logic                          in_sop,
  input  logic                          in_eop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [UUID_WIDTH-1:0]         out_uuid,
  output logic [NW_BITS-1:0]            out_wid,
  output logic [PC_BITS-1:0]            out_pc,
  output logic [NR_BITS-1:0]            out_rd,
  output logic                          out_wb,
  output logic [NUM_THREADS-1:0]        out_tmask,
  output logic [NUM_THREADS*XLEN-1:0]   out_data,
  output logic                          proto_err
);

  localparam int NUM_SLOTS = NUM_THREADS / NUM_LANES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]                  r_state;
  logic [UUID_WIDTH-1:0]       r_uuid;
  logic [NW_BITS-1:0]          r_wid;
  logic [PC_BITS-1:0]          r_pc;
  logic [NR_BITS-1:0]          r_rd;
  logic                        r_wb;
  logic [NUM_THREADS-1:0]      r_tmask;
  logic [NUM_THREADS*XLEN-1:0] r_data;
  logic                        r_proto_err;

  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_accum;
  logic                        w_wb_eff;
  logic                        w_hdr_load;
  logic                        w_clear;
  logic                        w_write;
  logic                        w_err;
  logic [1:0]                  w_state_nxt;
  logic [NUM_THREADS-1:0]      w_tmask_nxt;
  logic [NUM_THREADS*XLEN-1:0] w_data_nxt;

  // The accumulator doubles as the output register: a beat may only land
  // in FULL when the held packet is being consumed in the same cycle.
  assign in_ready   = (r_state != S_FULL) | out_ready;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = (r_state == S_FULL) & out_ready;
  assign w_accum    = (r_state == S_ACCUM);
  assign w_wb_eff   = in_sop ? in_wb : r_wb;

  always_comb begin
    w_state_nxt = r_state;
    w_tmask_nxt = r_tmask;
    w_data_nxt  = r_data;
    w_hdr_load  = 1'b0;
    w_clear     = 1'b0;
    w_write     = 1'b0;
    w_err       = 1'b0;

    if (w_out_fire) begin
      w_state_nxt = S_IDLE;
    end

    if (w_in_fire) begin
      if (in_sop) begin
        w_err       = w_accum;
        w_clear     = 1'b1;
        w_hdr_load  = 1'b1;
        w_write     = 1'b1;
        w_state_nxt = in_eop ? S_FULL : S_ACCUM;
      end else if (!w_accum) begin
        w_err       = 1'b1;
      end else if (in_wid != r_wid) begin
        w_err       = 1'b1;
      end else begin
        w_write     = 1'b1;
        if (in_eop) begin
          w_state_nxt = S_FULL;
        end
      end
    end

    if (w_clear) begin
      w_tmask_nxt = '0;
      w_data_nxt  = '0;
    end

    if (w_write) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (in_pid == PID_WIDTH'(s)) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            w_tmask_nxt[s*NUM_LANES + l] = in_tmask[l];
            w_data_nxt[(s*NUM_LANES + l)*XLEN +: XLEN] =
              (in_tmask[l] && w_wb_eff) ? in_data[l*XLEN +: XLEN] : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_uuid      <= '0;
      r_wid       <= '0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_wb        <= 1'b0;
      r_tmask     <= '0;
      r_data      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmask     <= w_tmask_nxt;
      r_data      <= w_data_nxt;
      r_proto_err <= w_err;
      if (w_hdr_load) begin
        r_uuid <= in_uuid;
        r_wid  <= in_wid;
        r_pc   <= in_pc;
        r_rd   <= in_rd;
        r_wb   <= in_wb;
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_uuid  = r_uuid;
  assign out_wid   = r_wid;
  assign out_pc    = r_pc;
  assign out_rd    = r_rd;
  assign out_wb    = r_wb;
  assign out_tmask = r_tmask;
  assign out_data  = r_data;
  assign proto_err = r_proto_err;

endmodule
